window_frame_scheduler: RTL and testbench
=========================================

Name: window_frame_scheduler

Overview:
- Sequences the sliding-window datapath for the spectrum analyzer: gates sample ingest (enable), raises enable_process once the window first fills, and issues one frame request per HOP samples to the downstream spectral engine.
- Owns the running sample index fed to the window's idx port, so no counter is kept in the sample-source logic.
- Arbitrates frame requests against a single-frame-in-flight engine; flags overruns when frames are dropped.

Parameters:
- SAMPLE_SIZE, 4096, window length in samples; first frame is issued after this many accepted samples.
- HOP, 1024, samples between successive frame requests once the window is full; 1 <= HOP <= SAMPLE_SIZE.
- IDX_W, 32, width of idx, frame_base_idx and the internal sample counter.
- CNT_W, 16, width of frame_count and drop_count.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a stream from IDLE or DONE.
- sample_valid  in  1  one sample presented to the window this cycle.
- stream_end  in  1  one-cycle pulse: source exhausted (EOF).
- proc_ready  in  1  engine can accept a frame_start.
- proc_done  in  1  one-cycle pulse: engine finished the in-flight frame.
- enable  out  1  window write enable.
- enable_process  out  1  window full, processing active.
- idx  out  IDX_W  count of samples accepted this stream.
- frame_start  out  1  one-cycle frame request to engine.
- frame_base_idx  out  IDX_W  idx of the oldest sample in the requested frame; valid with frame_start, held until the next request.
- frame_count  out  CNT_W  frames issued this stream.
- drop_count  out  CNT_W  frames dropped this stream.
- overrun  out  1  sticky; set on the first drop.
- busy  out  1  state is not IDLE and not DONE.
- done  out  1  high in DONE.

Behaviour:
- Reset (async, rst_n=0): state IDLE; every output 0; pending and in_flight 0; hop counter 0.
- States:
  - IDLE: start -> FILL, clear idx, counts and overrun; enable=1 from the next cycle.
  - FILL: each sample_valid increments idx. When the SAMPLE_SIZE-th sample is accepted (idx 4095 -> 4096), go to RUN, set enable_process=1 and set pending.
  - RUN: each sample_valid increments idx and the hop counter. When the hop counter reaches HOP, reset it to 0 and set pending.
  - DRAIN: enable=0; no samples counted. Go to DONE when pending=0 and in_flight=0.
  - DONE: done=1, enable=0, enable_process=0; counts held. start -> FILL as from IDLE.
- Issue rule (RUN or DRAIN): pending && proc_ready && !in_flight means the next cycle has frame_start=1, frame_base_idx=idx-SAMPLE_SIZE (current idx), frame_count++, pending=0, in_flight=1.
- proc_done clears in_flight. proc_done and issue in the same cycle: in_flight stays 1.
- Drop: a new hop completes while pending=1. Pending stays 1 and is updated to the newest frame (base advanced); drop_count++ saturating; overrun=1 sticky until the next start.
- Latency: frame_start is 1 cycle after the sample completing the window/hop when the engine is idle and ready.
- stream_end in FILL: go straight to DONE with no frame issued and enable_process never asserted.
- stream_end in RUN: -> DRAIN.
- sample_valid with stream_end in the same cycle: the sample is counted first, including hop/fill completion, then the transition is taken.
- sample_valid in IDLE, DRAIN or DONE is ignored. start outside IDLE/DONE is ignored.
- idx wraps modulo 2^IDX_W; frame_base_idx is computed modulo the same width.

Optional Feature:
- FRAME_TIMEOUT_EN, with parameter TIMEOUT_CYC (default 65535).
- Defined: a counter runs while in_flight. If it reaches TIMEOUT_CYC without proc_done, in_flight is force-cleared, extra output timeout (sticky, cleared by start) is set, and scheduling continues.
- Undefined: no counter, no timeout port; in_flight is cleared only by proc_done, and DRAIN may wait indefinitely.

Test Plan (SAMPLE_SIZE=8, HOP=4, IDX_W=32):
- Reset mid-RUN with idx=10: rst_n=0 -> all outputs 0 asynchronously, state IDLE; start then 8 samples -> first frame_start, base 0.
- Engine always ready, proc_done 2 cycles after each frame_start, 16 contiguous samples -> frame_start after samples 8, 12, 16 with base 0, 4, 8; frame_count=3; overrun=0.
- proc_ready=0 through samples 8-16 -> drops at samples 12 and 16; drop_count=2, overrun=1; after ready, a single frame_start with base 8.
- stream_end at sample 5 (FILL) -> DONE; frame_count=0; enable_process never 1.
- stream_end together with sample 12 -> hop counted, frame base 4 issued in DRAIN, DONE after its proc_done; enable=0 the cycle after stream_end.
- FRAME_TIMEOUT_EN, TIMEOUT_CYC=20, proc_done withheld -> timeout=1 after 20 cycles in flight; the next pending frame is issued.

Source files
------------

// File: rtl/window_frame_scheduler_if.sv
// Frame request handshake between the window scheduler (master) and the
// single-frame-in-flight spectral engine (slave).
interface window_frame_scheduler_if #(
  parameter int unsigned IDX_W = 32
);
  logic             frame_start;
  logic [IDX_W-1:0] frame_base_idx;
  logic             proc_ready;
  logic             proc_done;

  modport master (
    output frame_start,
    output frame_base_idx,
    input  proc_ready,
    input  proc_done
  );

  modport slave (
    input  frame_start,
    input  frame_base_idx,
    output proc_ready,
    output proc_done
  );
endinterface

// File: rtl/window_frame_scheduler.sv
// Sliding-window frame scheduler: gates sample ingest, owns the running sample
// index, raises enable_process once the window first fills and requests one
// frame per HOP samples from a single-frame-in-flight engine, counting drops.
// Optional macro FRAME_TIMEOUT_EN adds TIMEOUT_CYC and a sticky timeout output
// that force-clears a frame the engine never reports as done.
module window_frame_scheduler #(
  parameter int unsigned SAMPLE_SIZE = 4096,
  parameter int unsigned HOP         = 1024,
  parameter int unsigned IDX_W       = 32,
  parameter int unsigned CNT_W       = 16
`ifdef FRAME_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 65535
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sample_valid,
  input  logic                  stream_end,
  output logic                  enable,
  output logic                  enable_process,
  output logic [IDX_W-1:0]      idx,
  output logic [CNT_W-1:0]      frame_count,
  output logic [CNT_W-1:0]      drop_count,
  output logic                  overrun,
  output logic                  busy,
  output logic                  done,
`ifdef FRAME_TIMEOUT_EN
  output logic                  timeout,
`endif
  window_frame_scheduler_if.master eng
);

  typedef enum logic [2:0] {StIdle, StFill, StRun, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] hop_q, hop_d;
  logic             pending_q, pending_d;
  logic [IDX_W-1:0] pend_base_q, pend_base_d;
  logic             in_flight_q, in_flight_d;
  logic             fs_q, fs_d;
  logic [IDX_W-1:0] fbase_q, fbase_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic             ovr_q, ovr_d;
  logic             ep_q, ep_d;
  logic             frame_evt;
  logic             filled;
`ifdef FRAME_TIMEOUT_EN
  logic [31:0]      to_cnt_q, to_cnt_d;
  logic             tmo_q, tmo_d;
`endif

  // Next-state: sample counting, frame completion, drop tracking and issue.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    hop_d       = hop_q;
    pending_d   = pending_q;
    pend_base_d = pend_base_q;
    in_flight_d = in_flight_q;
    fs_d        = 1'b0;
    fbase_d     = fbase_q;
    fcnt_d      = fcnt_q;
    dcnt_d      = dcnt_q;
    ovr_d       = ovr_q;
    ep_d        = ep_q;
    frame_evt   = 1'b0;
    filled      = 1'b0;
`ifdef FRAME_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
    tmo_d       = tmo_q;
`endif

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d   = StFill;
          idx_d     = '0;
          hop_d     = '0;
          pending_d = 1'b0;
          fcnt_d    = '0;
          dcnt_d    = '0;
          ovr_d     = 1'b0;
          ep_d      = 1'b0;
`ifdef FRAME_TIMEOUT_EN
          tmo_d     = 1'b0;
`endif
        end
      end
      StFill: begin
        if (sample_valid) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == IDX_W'(SAMPLE_SIZE - 1)) begin
            filled    = 1'b1;
            frame_evt = 1'b1;
            state_d   = StRun;
            ep_d      = 1'b1;
          end
        end
        // A sample that completes the window is counted before EOF is honoured.
        if (stream_end) state_d = filled ? StDrain : StDone;
      end
      StRun: begin
        if (sample_valid) begin
          idx_d = idx_q + 1'b1;
          if (hop_q == IDX_W'(HOP - 1)) begin
            hop_d     = '0;
            frame_evt = 1'b1;
          end else begin
            hop_d = hop_q + 1'b1;
          end
        end
        if (stream_end) state_d = StDrain;
      end
      StDrain: begin
        if (!pending_q && !in_flight_q) begin
          state_d = StDone;
          ep_d    = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    // A completed frame replaces an unissued one; the older frame is lost.
    if (frame_evt) begin
      if (pending_q) begin
        ovr_d = 1'b1;
        if (dcnt_q != {CNT_W{1'b1}}) dcnt_d = dcnt_q + 1'b1;
      end
      pending_d   = 1'b1;
      pend_base_d = idx_d - IDX_W'(SAMPLE_SIZE);
    end

    // Issue looks at the just-completed frame so the request trails its last sample by one cycle.
    if (pending_d && eng.proc_ready && !in_flight_q) begin
      fs_d        = 1'b1;
      fbase_d     = pend_base_d;
      fcnt_d      = fcnt_q + 1'b1;
      pending_d   = 1'b0;
      in_flight_d = 1'b1;
`ifdef FRAME_TIMEOUT_EN
      to_cnt_d    = '0;
`endif
    end else if (eng.proc_done) begin
      in_flight_d = 1'b0;
`ifdef FRAME_TIMEOUT_EN
      to_cnt_d    = '0;
    end else if (in_flight_q) begin
      if (to_cnt_q == 32'(TIMEOUT_CYC - 1)) begin
        in_flight_d = 1'b0;
        tmo_d       = 1'b1;
        to_cnt_d    = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
`endif
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      hop_q       <= '0;
      pending_q   <= 1'b0;
      pend_base_q <= '0;
      in_flight_q <= 1'b0;
      fs_q        <= 1'b0;
      fbase_q     <= '0;
      fcnt_q      <= '0;
      dcnt_q      <= '0;
      ovr_q       <= 1'b0;
      ep_q        <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
      to_cnt_q    <= '0;
      tmo_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hop_q       <= hop_d;
      pending_q   <= pending_d;
      pend_base_q <= pend_base_d;
      in_flight_q <= in_flight_d;
      fs_q        <= fs_d;
      fbase_q     <= fbase_d;
      fcnt_q      <= fcnt_d;
      dcnt_q      <= dcnt_d;
      ovr_q       <= ovr_d;
      ep_q        <= ep_d;
`ifdef FRAME_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign enable             = (state_q == StFill) || (state_q == StRun);
  assign enable_process     = ep_q;
  assign idx                = idx_q;
  assign frame_count        = fcnt_q;
  assign drop_count         = dcnt_q;
  assign overrun            = ovr_q;
  assign busy               = (state_q != StIdle) && (state_q != StDone);
  assign done               = (state_q == StDone);
  assign eng.frame_start    = fs_q;
  assign eng.frame_base_idx = fbase_q;
`ifdef FRAME_TIMEOUT_EN
  assign timeout            = tmo_q;
`endif

endmodule

// File: tb/tb_window_frame_scheduler.sv
// Directed bench for window_frame_scheduler (SAMPLE_SIZE=8, HOP=4) with a
// stream-level reference model checked every cycle plus literal expectations.
module tb_window_frame_scheduler;
  localparam int S  = 8;
  localparam int H  = 4;
  localparam int TO = 20;
  localparam int PIdle = 0, PFill = 1, PRun = 2, PDrain = 3, PDone = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, sample_valid, stream_end;
  logic        enable, enable_process, overrun, busy, done;
  logic [31:0] idx;
  logic [15:0] frame_count, drop_count;
`ifdef FRAME_TIMEOUT_EN
  logic        timeout;
`endif

  window_frame_scheduler_if #(.IDX_W(32)) bus ();

  window_frame_scheduler #(
    .SAMPLE_SIZE(S),
    .HOP        (H),
    .IDX_W      (32),
    .CNT_W      (16)
`ifdef FRAME_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(TO)
`endif
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .sample_valid  (sample_valid),
    .stream_end    (stream_end),
    .enable        (enable),
    .enable_process(enable_process),
    .idx           (idx),
    .frame_count   (frame_count),
    .drop_count    (drop_count),
    .overrun       (overrun),
    .busy          (busy),
    .done          (done),
`ifdef FRAME_TIMEOUT_EN
    .timeout       (timeout),
`endif
    .eng           (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: stream-level bookkeeping of accepted samples and frames.
  int m_ph = PIdle, m_n = 0, m_pbase = 0, m_fbase = 0, m_fc = 0, m_dc = 0, m_age = 0;
  bit m_pend = 0, m_infl = 0, m_fs = 0, m_ovr = 0, m_ep = 0, m_tmo = 0;

  task automatic model_step();
    bit evt;
    int nb;
    evt = 0;
    nb  = 0;
    if (!rst_n) begin
      m_ph = PIdle; m_n = 0; m_pbase = 0; m_fbase = 0; m_fc = 0; m_dc = 0; m_age = 0;
      m_pend = 0; m_infl = 0; m_fs = 0; m_ovr = 0; m_ep = 0; m_tmo = 0;
    end else begin
      m_fs = 0;
      case (m_ph)
        PIdle, PDone: begin
          if (start) begin
            m_ph = PFill; m_n = 0; m_fc = 0; m_dc = 0; m_ovr = 0; m_pend = 0; m_ep = 0;
            m_tmo = 0;
          end
        end
        PFill, PRun: begin
          if (sample_valid) begin
            m_n++;
            // A frame ends at sample S, then at every further multiple of H.
            if (m_n >= S && (m_n - S) % H == 0) begin
              evt = 1;
              nb  = m_n - S;
            end
            if (m_n == S) begin
              m_ph = PRun;
              m_ep = 1;
            end
          end
          if (stream_end) m_ph = (m_ph == PRun) ? PDrain : PDone;
        end
        PDrain: begin
          if (!m_pend && !m_infl) begin
            m_ph = PDone;
            m_ep = 0;
          end
        end
        default: ;
      endcase
      if (evt) begin
        if (m_pend) begin
          m_ovr = 1;
          if (m_dc < 65535) m_dc++;
        end
        m_pend  = 1;
        m_pbase = nb;
      end
      if (m_pend && bus.proc_ready && !m_infl) begin
        m_fs = 1; m_fbase = m_pbase; m_fc++; m_pend = 0; m_infl = 1; m_age = 0;
      end else if (bus.proc_done) begin
        m_infl = 0;
        m_age  = 0;
`ifdef FRAME_TIMEOUT_EN
      end else if (m_infl) begin
        m_age++;
        if (m_age == TO) begin
          m_infl = 0;
          m_tmo  = 1;
          m_age  = 0;
        end
`endif
      end
    end
  endtask

  int fs_log[$];
  bit fs_drain[$];
  bit ep_seen = 0;

  // Compare DUT against the model 1 time unit after each rising edge.
  always @(posedge clk) begin
    model_step();
    #1;
    chk("enable", enable, (m_ph == PFill || m_ph == PRun));
    chk("enable_process", enable_process, m_ep);
    chk("idx", idx, m_n);
    chk("frame_start", bus.frame_start, m_fs);
    chk("frame_base_idx", bus.frame_base_idx, m_fbase);
    chk("frame_count", frame_count, m_fc);
    chk("drop_count", drop_count, m_dc);
    chk("overrun", overrun, m_ovr);
    chk("busy", busy, (m_ph == PFill || m_ph == PRun || m_ph == PDrain));
    chk("done", done, (m_ph == PDone));
`ifdef FRAME_TIMEOUT_EN
    chk("timeout", timeout, m_tmo);
`endif
    if (bus.frame_start) begin
      fs_log.push_back(int'(bus.frame_base_idx));
      fs_drain.push_back(busy && !enable);
    end
    if (enable_process) ep_seen = 1;
  end

  // Engine stand-in: pulses proc_done two cycles after each frame_start.
  bit auto_done = 1;
  bit fs_d0 = 0, fs_d1 = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      fs_d0 = 0;
      fs_d1 = 0;
      bus.proc_done = 1'b0;
    end else begin
      bus.proc_done = auto_done && fs_d1;
      fs_d1 = fs_d0;
      fs_d0 = bus.frame_start;
    end
  end

  task automatic cyc(input bit s, input bit v, input bit e);
    start = s; sample_valid = v; stream_end = e;
    @(negedge clk);
    start = 0; sample_valid = 0; stream_end = 0;
  endtask

  task automatic samples(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 0);
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!done && k < 80) begin
      cyc(0, 0, 0);
      k++;
    end
    chk(name, done, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 0; start = 0; sample_valid = 0; stream_end = 0;
    bus.proc_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_idx", idx, 0);
    rst_n = 1;
    cyc(0, 0, 0);

    // Reset mid-RUN with idx=10, then a fresh fill.
    cyc(1, 0, 0);
    samples(10);
    chk("t1_idx_pre_reset", idx, 10);
    #2 rst_n = 0;
    #1;
    chk("t1_async_enable", enable, 0);
    chk("t1_async_ep", enable_process, 0);
    chk("t1_async_idx", idx, 0);
    chk("t1_async_fcnt", frame_count, 0);
    chk("t1_async_busy", busy, 0);
    @(negedge clk);
    cyc(0, 0, 0);
    rst_n = 1;
    fs_log.delete(); fs_drain.delete();
    cyc(1, 0, 0);
    samples(8);
    cyc(0, 0, 0);
    chk("t1_frames", fs_log.size(), 1);
    if (fs_log.size() == 1) chk("t1_base", fs_log[0], 0);
    cyc(0, 0, 1);
    wait_done("t1_done");

    // 16 contiguous samples, engine always ready.
    fs_log.delete(); fs_drain.delete();
    cyc(1, 0, 0);
    samples(16);
    repeat (3) cyc(0, 0, 0);
    chk("t2_frames", fs_log.size(), 3);
    if (fs_log.size() == 3) begin
      chk("t2_base0", fs_log[0], 0);
      chk("t2_base1", fs_log[1], 4);
      chk("t2_base2", fs_log[2], 8);
    end
    chk("t2_fcnt", frame_count, 3);
    chk("t2_overrun", overrun, 0);
    chk("t2_idx", idx, 16);
    cyc(0, 0, 1);
    wait_done("t2_done");

    // Engine not ready through samples 8-16: two drops, newest frame survives.
    fs_log.delete(); fs_drain.delete();
    cyc(1, 0, 0);
    for (int i = 1; i <= 16; i++) begin
      bus.proc_ready = (i < 8);
      cyc(0, 1, 0);
    end
    repeat (2) cyc(0, 0, 0);
    chk("t3_no_frames", fs_log.size(), 0);
    chk("t3_drops", drop_count, 2);
    chk("t3_overrun", overrun, 1);
    bus.proc_ready = 1'b1;
    repeat (4) cyc(0, 0, 0);
    chk("t3_frames", fs_log.size(), 1);
    if (fs_log.size() == 1) chk("t3_base", fs_log[0], 8);
    chk("t3_fcnt", frame_count, 1);
    cyc(0, 0, 1);
    wait_done("t3_done");

    // EOF with sample 5, still filling.
    ep_seen = 0;
    fs_log.delete(); fs_drain.delete();
    cyc(1, 0, 0);
    samples(4);
    cyc(0, 1, 1);
    cyc(0, 0, 0);
    chk("t4_done", done, 1);
    chk("t4_fcnt", frame_count, 0);
    chk("t4_ep_seen", ep_seen, 0);
    chk("t4_idx", idx, 5);

    // EOF together with sample 12: hop still counted, frame issued while draining.
    fs_log.delete(); fs_drain.delete();
    cyc(1, 0, 0);
    samples(11);
    cyc(0, 1, 1);
    chk("t5_enable_after_eof", enable, 0);
    chk("t5_busy_draining", busy, 1);
    wait_done("t5_done");
    chk("t5_frames", fs_log.size(), 2);
    if (fs_log.size() == 2) begin
      chk("t5_base0", fs_log[0], 0);
      chk("t5_base1", fs_log[1], 4);
      chk("t5_base1_in_drain", fs_drain[1], 1);
    end
    chk("t5_fcnt", frame_count, 2);

`ifdef FRAME_TIMEOUT_EN
    // proc_done withheld: frame 0 times out after TO cycles, then frame 4 goes out.
    auto_done = 0;
    fs_log.delete(); fs_drain.delete();
    cyc(1, 0, 0);
    samples(12);
    repeat (TO) cyc(0, 0, 0);
    chk("t6_timeout", timeout, 1);
    chk("t6_frames", fs_log.size(), 2);
    if (fs_log.size() == 2) chk("t6_base1", fs_log[1], 4);
    cyc(0, 0, 1);
    wait_done("t6_done");
    auto_done = 1;
`endif

    cyc(0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
